hdc_session_ctrl: RTL and testbench

Session controller that sequences the HDC classification pipeline (feature, spatial, temporal, associative memory) for host-issued train and predict sessions. It accepts host commands and drives the pipeline mode and label inputs. It gates ADC sample strobes into a valid/ready handshake, controls the pipeline clock enable, and captures the classification results. The raw sample bus does not pass through this block; it goes straight to the pipeline.

---
 rtl/hdc_session_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_hdc_session_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdc_session_ctrl.sv
// Session controller for the HDC pipeline: host train/predict sessions, ADC sample
// gating, pipeline clock enable and result capture. Optional filter: HDC_RESULT_FILTER_EN.
module hdc_session_ctrl #(
  parameter int MODE_WIDTH     = 2,
  parameter int LABEL_WIDTH    = 5,
  parameter int DISTANCE_WIDTH = 10,
  parameter int CNT_WIDTH      = 16,
  parameter int GATE_CYCLES    = 64,
  parameter int DRAIN_CYCLES   = 256
`ifdef HDC_RESULT_FILTER_EN
  ,
  parameter int FILTER_DEPTH   = 3
`endif
) (
  input  logic                      Clk_CI,
  input  logic                      Reset_RI,
  input  logic                      CmdValid_SI,
  output logic                      CmdReady_SO,
  input  logic [1:0]                CmdOp_DI,
  input  logic [LABEL_WIDTH-1:0]    CmdLabel_DI,
  input  logic [CNT_WIDTH-1:0]      CmdCount_DI,
  input  logic                      SampleValid_SI,
  output logic                      PipeValid_SO,
  input  logic                      PipeReady_SI,
  output logic [MODE_WIDTH-1:0]     PipeMode_SO,
  output logic [LABEL_WIDTH-1:0]    PipeLabel_SO,
  output logic                      PipeClkEn_SO,
  input  logic                      ResValid_SI,
  output logic                      ResReady_SO,
  input  logic [LABEL_WIDTH-1:0]    ResLabel_DI,
  input  logic [DISTANCE_WIDTH-1:0] ResDistance_DI,
  output logic [LABEL_WIDTH-1:0]    LabelOut_DO,
  output logic [DISTANCE_WIDTH-1:0] DistanceOut_DO,
  output logic                      ResultStrobe_SO,
  output logic                      Busy_SO,
  output logic                      Done_SO,
  output logic [CNT_WIDTH-1:0]      SampleCnt_DO,
  output logic [CNT_WIDTH-1:0]      DropCnt_DO,
  output logic [1:0]                State_DO,
  output logic [CNT_WIDTH-1:0]      ResCnt_DO
);

  // Handshakes (command, pipeline sample, result): a transfer happens on a rising
  // edge where valid and ready are both high; a raised valid holds until that edge.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int IDLE_W = $clog2(DRAIN_CYCLES) + 1;
  localparam int GATE_W = $clog2(GATE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state, state_next;
  logic                   cmd_hs, op_stop, start, stop_now;
  logic                   stopping, accepting, sample_take;
  logic                   pipe_hs, target_hit, drain_go, drop, idle_done;
  logic                   valid_next, busy_now, busy_next, res_hs, capture;
  logic [CNT_WIDTH-1:0]   target, sample_inc;
  logic [IDLE_W-1:0]      idle_cnt;
  logic [GATE_W-1:0]      gate_cnt, gate_next;

  assign ResReady_SO = ~Reset_RI;
  assign res_hs      = ResValid_SI && ResReady_SO;

  always_comb begin
    cmd_hs      = CmdValid_SI && CmdReady_SO;
    op_stop     = (CmdOp_DI == 2'd0) || (CmdOp_DI == 2'd3);
    start       = (state == S_IDLE) && cmd_hs && !op_stop;
    stop_now    = (state == S_RUN) && cmd_hs && op_stop;
    accepting   = (state == S_RUN) && !stopping && !stop_now;
    sample_take = SampleValid_SI && accepting;
    pipe_hs     = PipeValid_SO && PipeReady_SI;
    sample_inc  = (SampleCnt_DO == CNT_MAX) ? SampleCnt_DO : SampleCnt_DO + CNT_WIDTH'(1);
    target_hit  = pipe_hs && (target != '0) && (sample_inc == target);
    drain_go    = target_hit || ((stopping || stop_now) && (!PipeValid_SO || pipe_hs));
    drop        = sample_take && PipeValid_SO && !pipe_hs;
    idle_done   = !ResValid_SI && (idle_cnt == IDLE_W'(DRAIN_CYCLES - 1));
  end

  // FSM: state register
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) state <= S_IDLE;
    else          state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start)     state_next = S_RUN;
      S_RUN:   if (drain_go)  state_next = S_DRAIN;
      S_DRAIN: if (idle_done) state_next = S_DONE;
      S_DONE:                 state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    CmdReady_SO = (state == S_IDLE) || (state == S_RUN);
    Busy_SO     = (state == S_RUN) || (state == S_DRAIN);
    Done_SO     = (state == S_DONE);
    State_DO    = state;
  end

  // A sample coinciding with the target-reaching handshake is ignored, not queued.
  always_comb begin
    valid_next = PipeValid_SO;
    if (state != S_RUN)   valid_next = 1'b0;
    else if (pipe_hs)     valid_next = sample_take && !target_hit;
    else if (sample_take) valid_next = 1'b1;
  end

  // The clock-enable hold restarts on any activity and on every busy cycle, so it
  // also stays up for GATE_CYCLES after the session leaves DRAIN.
  always_comb begin
    busy_now  = (state == S_RUN) || (state == S_DRAIN);
    busy_next = (state_next == S_RUN) || (state_next == S_DRAIN);
    if (busy_now || busy_next || SampleValid_SI || ResValid_SI)
      gate_next = GATE_W'(GATE_CYCLES);
    else if (gate_cnt != '0)
      gate_next = gate_cnt - GATE_W'(1);
    else
      gate_next = '0;
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      PipeValid_SO <= 1'b0;
      PipeMode_SO  <= '0;
      PipeLabel_SO <= '0;
      PipeClkEn_SO <= 1'b0;
      SampleCnt_DO <= '0;
      DropCnt_DO   <= '0;
      target       <= '0;
      stopping     <= 1'b0;
      idle_cnt     <= '0;
      gate_cnt     <= '0;
    end else begin
      PipeValid_SO <= valid_next;
      stopping     <= (state_next == S_RUN) && (stopping || stop_now);
      gate_cnt     <= gate_next;
      PipeClkEn_SO <= (gate_next != '0) || valid_next;
      if (start) begin
        PipeMode_SO  <= (CmdOp_DI == 2'd1) ? MODE_WIDTH'(1) : '0;
        PipeLabel_SO <= (CmdOp_DI == 2'd1) ? CmdLabel_DI : '0;
        target       <= CmdCount_DI;
        SampleCnt_DO <= '0;
        DropCnt_DO   <= '0;
      end else begin
        if (pipe_hs) SampleCnt_DO <= sample_inc;
        if (drop && DropCnt_DO != CNT_MAX) DropCnt_DO <= DropCnt_DO + CNT_WIDTH'(1);
      end
      if (state != S_DRAIN || ResValid_SI) idle_cnt <= '0;
      else                                 idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

`ifdef HDC_RESULT_FILTER_EN
  localparam int RUN_W = $clog2(FILTER_DEPTH + 1);

  logic [RUN_W-1:0]       run_len, run_len_next;
  logic [LABEL_WIDTH-1:0] run_label;

  always_comb begin
    run_len_next = RUN_W'(1);
    if (run_len != '0 && ResLabel_DI == run_label)
      run_len_next = (run_len == RUN_W'(FILTER_DEPTH)) ? run_len : run_len + RUN_W'(1);
  end

  // Train-mode results bypass the label-run requirement.
  assign capture = res_hs &&
                   ((PipeMode_SO == MODE_WIDTH'(1)) || (run_len_next == RUN_W'(FILTER_DEPTH)));

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI || start) begin
      run_len   <= '0;
      run_label <= '0;
    end else if (res_hs) begin
      run_len   <= run_len_next;
      run_label <= ResLabel_DI;
    end
  end
`else
  assign capture = res_hs;
`endif

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      LabelOut_DO     <= '0;
      DistanceOut_DO  <= '0;
      ResultStrobe_SO <= 1'b0;
      ResCnt_DO       <= '0;
    end else begin
      ResultStrobe_SO <= capture;
      if (capture) begin
        LabelOut_DO    <= ResLabel_DI;
        DistanceOut_DO <= ResDistance_DI;
      end
      if (start)                              ResCnt_DO <= '0;
      else if (res_hs && ResCnt_DO != CNT_MAX) ResCnt_DO <= ResCnt_DO + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hdc_session_ctrl.sv
// Self-checking bench for hdc_session_ctrl; build with HDC_RESULT_FILTER_EN to
// exercise the result filter expectations.
module tb_hdc_session_ctrl;

  localparam int MW = 2;
  localparam int LW = 5;
  localparam int DW = 10;
  localparam int CW = 16;
`ifdef HDC_RESULT_FILTER_EN
  localparam int RES_REPEAT = 3;
`else
  localparam int RES_REPEAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [LW-1:0] cmd_label;
  logic [CW-1:0] cmd_count;
  logic          sample_valid, pipe_valid, pipe_ready;
  logic [MW-1:0] pipe_mode;
  logic [LW-1:0] pipe_label;
  logic          pipe_clk_en;
  logic          res_valid, res_ready;
  logic [LW-1:0] res_label;
  logic [DW-1:0] res_distance;
  logic [LW-1:0] label_out;
  logic [DW-1:0] distance_out;
  logic          result_strobe, busy, done;
  logic [CW-1:0] sample_cnt, drop_cnt, res_cnt;
  logic [1:0]    state;

  logic [LW+DW-1:0] exp_q[$];
  logic [MW+LW-1:0] iss_q[$];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hdc_session_ctrl dut (
    .Clk_CI(clk), .Reset_RI(rst),
    .CmdValid_SI(cmd_valid), .CmdReady_SO(cmd_ready), .CmdOp_DI(cmd_op),
    .CmdLabel_DI(cmd_label), .CmdCount_DI(cmd_count),
    .SampleValid_SI(sample_valid), .PipeValid_SO(pipe_valid), .PipeReady_SI(pipe_ready),
    .PipeMode_SO(pipe_mode), .PipeLabel_SO(pipe_label), .PipeClkEn_SO(pipe_clk_en),
    .ResValid_SI(res_valid), .ResReady_SO(res_ready), .ResLabel_DI(res_label),
    .ResDistance_DI(res_distance), .LabelOut_DO(label_out), .DistanceOut_DO(distance_out),
    .ResultStrobe_SO(result_strobe), .Busy_SO(busy), .Done_SO(done),
    .SampleCnt_DO(sample_cnt), .DropCnt_DO(drop_cnt), .State_DO(state), .ResCnt_DO(res_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [LW-1:0] lab, input logic [CW-1:0] cnt);
    cmd_valid = 1'b1; cmd_op = op; cmd_label = lab; cmd_count = cnt;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [75:0] outs;
    rst = 1'b1;
    repeat (3) step();
    outs = {pipe_valid, pipe_mode, pipe_label, pipe_clk_en, res_ready, label_out, distance_out,
            result_strobe, busy, done, sample_cnt, drop_cnt, res_cnt};
    n_total++; if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs); else n_pass++;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); else n_pass++;
    n_total++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
    rst = 1'b0;
    step();
    n_total++; if (res_ready !== 1'b1) $display("FAIL res_ready: got %b expected 1", res_ready); else n_pass++;
  endtask

  task automatic test_train();
    int hs = 0, pushed = 0, drain = 0, wait_n = 0, c = 0;
    logic [MW+LW-1:0] e;
    pipe_ready = 1'b1;
    send_cmd(2'd1, 5'd7, 16'd4);
    n_total++; if (state !== 2'd1) $display("FAIL train_run_state: got %0d expected 1", state); else n_pass++;
    n_total++; if (pipe_clk_en !== 1'b1) $display("FAIL train_clk_en: got %b expected 1", pipe_clk_en); else n_pass++;
    for (int i = 0; i < 60; i++) begin
      if (pipe_valid && pipe_ready) begin
        hs++;
        n_total++;
        if (iss_q.size() == 0) $display("FAIL train_issue: got handshake %0d expected none", hs);
        else begin
          e = iss_q.pop_front();
          if ({pipe_mode, pipe_label} !== e) $display("FAIL train_issue: got %h expected %h", {pipe_mode, pipe_label}, e);
          else n_pass++;
        end
      end
      if (state == 2'd2) drain++;
      sample_valid = (i % 10 == 0);
      if (sample_valid && pushed < 4) begin
        iss_q.push_back({2'd1, 5'd7});
        pushed++;
      end
      step();
    end
    sample_valid = 1'b0;
    n_total++; if (hs != 4) $display("FAIL train_handshakes: got %0d expected 4", hs); else n_pass++;
    n_total++; if (sample_cnt !== 16'd4) $display("FAIL train_sample_cnt: got %0d expected 4", sample_cnt); else n_pass++;
    n_total++; if (state !== 2'd2) $display("FAIL train_drain: got %0d expected 2", state); else n_pass++;
    n_total++; if (iss_q.size() != 0) $display("FAIL train_queue: got %0d left expected 0", iss_q.size()); else n_pass++;
    while (done !== 1'b1 && wait_n < 400) begin
      if (state == 2'd2) drain++;
      step();
      wait_n++;
    end
    n_total++; if (done !== 1'b1) $display("FAIL train_done: got %b expected 1", done); else n_pass++;
    n_total++; if (drain != 256) $display("FAIL train_drain_len: got %0d expected 256", drain); else n_pass++;
    n_total++; if (pipe_clk_en !== 1'b1) $display("FAIL train_en_at_done: got %b expected 1", pipe_clk_en); else n_pass++;
    step();
    c = 1;
    n_total++; if ({done, state} !== 3'b0_00) $display("FAIL train_after_done: got %b expected 000", {done, state}); else n_pass++;
    while (pipe_clk_en === 1'b1 && c < 200) begin
      step();
      c++;
    end
    n_total++; if (c != 64) $display("FAIL train_gate: got %0d expected 64", c); else n_pass++;
  endtask

  task automatic test_predict_backpressure();
    int drops = 0;
    bit pend = 0, held_ok = 1;
    logic [MW+LW-1:0] e;
    pipe_ready = 1'b0;
    send_cmd(2'd2, 5'd9, 16'd0);
    for (int i = 0; i < 20; i++) begin
      if (pend && pipe_valid !== 1'b1) held_ok = 0;
      sample_valid = (i == 0 || i == 7 || i == 14);
      if (sample_valid) begin
        if (pend) drops++;
        else begin
          iss_q.push_back({2'd0, 5'd0});
          pend = 1;
        end
      end
      step();
    end
    sample_valid = 1'b0;
    n_total++; if (!held_ok || pipe_valid !== 1'b1) $display("FAIL pred_valid_held: got %b expected 1", pipe_valid); else n_pass++;
    n_total++; if (drop_cnt !== CW'(drops)) $display("FAIL pred_drops: got %0d expected %0d", drop_cnt, drops); else n_pass++;
    pipe_ready = 1'b1;
    if (pipe_valid && pipe_ready) begin
      n_total++;
      e = iss_q.pop_front();
      if ({pipe_mode, pipe_label} !== e) $display("FAIL pred_issue: got %h expected %h", {pipe_mode, pipe_label}, e);
      else n_pass++;
    end
    step();
    n_total++; if (sample_cnt !== 16'd1) $display("FAIL pred_sample_cnt: got %0d expected 1", sample_cnt); else n_pass++;
    n_total++; if (iss_q.size() != 0) $display("FAIL pred_queue: got %0d left expected 0", iss_q.size()); else n_pass++;
    n_total++; if (pipe_valid !== 1'b0) $display("FAIL pred_valid_drop: got %b expected 0", pipe_valid); else n_pass++;
  endtask

  task automatic test_stop_collision();
    cmd_valid = 1'b1; cmd_op = 2'd0; sample_valid = 1'b1;
    step();
    cmd_valid = 1'b0; sample_valid = 1'b0;
    n_total++; if (pipe_valid !== 1'b0) $display("FAIL stop_no_issue: got %b expected 0", pipe_valid); else n_pass++;
    n_total++; if (drop_cnt !== 16'd2) $display("FAIL stop_drops: got %0d expected 2", drop_cnt); else n_pass++;
    n_total++; if (state !== 2'd2) $display("FAIL stop_drain: got %0d expected 2", state); else n_pass++;
    n_total++; if (cmd_ready !== 1'b0) $display("FAIL stop_cmd_ready: got %b expected 0", cmd_ready); else n_pass++;
  endtask

  task automatic test_result();
    int wait_n = 0;
    logic [LW+DW-1:0] e;
    for (int k = 0; k < RES_REPEAT; k++) begin
      if (k > 0) begin
        n_total++; if (result_strobe !== 1'b0) $display("FAIL result_early: got %b expected 0", result_strobe); else n_pass++;
      end
      res_valid = 1'b1; res_label = 5'd12; res_distance = 10'd300;
      if (k == RES_REPEAT - 1) exp_q.push_back({5'd12, 10'd300});
      step();
    end
    res_valid = 1'b0;
    n_total++; if (result_strobe !== 1'b1) $display("FAIL result_strobe: got %b expected 1", result_strobe); else n_pass++;
    if (exp_q.size() != 0) begin
      n_total++;
      e = exp_q.pop_front();
      if ({label_out, distance_out} !== e) $display("FAIL result_value: got %h expected %h", {label_out, distance_out}, e);
      else n_pass++;
    end
    step();
    n_total++; if (result_strobe !== 1'b0) $display("FAIL result_single: got %b expected 0", result_strobe); else n_pass++;
    while (state !== 2'd0 && wait_n < 400) begin
      step();
      wait_n++;
    end
    n_total++; if (state !== 2'd0) $display("FAIL result_idle: got %0d expected 0", state); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] labs[5] = '{5'd3, 5'd3, 5'd5, 5'd5, 5'd5};
    int strobes = 0, exp_strobes = 0;
    logic [LW+DW-1:0] e;
    for (int i = 0; i < 7; i++) begin
      if (result_strobe === 1'b1) begin
        strobes++;
        n_total++;
        if (exp_q.size() == 0) $display("FAIL b2b_strobe: got strobe %0d expected none", strobes);
        else begin
          e = exp_q.pop_front();
          if ({label_out, distance_out} !== e) $display("FAIL b2b_value: got %h expected %h", {label_out, distance_out}, e);
          else n_pass++;
        end
      end
      if (i < 5) begin
        res_valid = 1'b1; res_label = labs[i]; res_distance = DW'(100 + i);
`ifdef HDC_RESULT_FILTER_EN
        if (i == 4) begin exp_q.push_back({labs[i], DW'(100 + i)}); exp_strobes++; end
`else
        exp_q.push_back({labs[i], DW'(100 + i)}); exp_strobes++;
`endif
      end else res_valid = 1'b0;
      step();
    end
    n_total++; if (strobes != exp_strobes) $display("FAIL b2b_count: got %0d expected %0d", strobes, exp_strobes); else n_pass++;
    n_total++; if ({label_out, distance_out} !== {5'd5, 10'd104}) $display("FAIL b2b_final: got %0d/%0d expected 5/104", label_out, distance_out); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [75:0] outs;
    pipe_ready = 1'b0;
    send_cmd(2'd1, 5'd9, 16'd0);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    n_total++; if ({pipe_valid, pipe_mode, pipe_label} !== {1'b1, 2'd1, 5'd9}) $display("FAIL mid_pending: got %h expected %h", {pipe_valid, pipe_mode, pipe_label}, {1'b1, 2'd1, 5'd9}); else n_pass++;
    rst = 1'b1;
    step();
    outs = {pipe_valid, pipe_mode, pipe_label, pipe_clk_en, res_ready, label_out, distance_out,
            result_strobe, busy, done, sample_cnt, drop_cnt, res_cnt};
    n_total++; if (outs !== '0) $display("FAIL mid_reset_outputs: got %h expected 0", outs); else n_pass++;
    n_total++; if ({cmd_ready, state} !== 3'b1_00) $display("FAIL mid_reset_idle: got %b expected 100", {cmd_ready, state}); else n_pass++;
    rst = 1'b0;
    step();
    n_total++; if ({pipe_valid, res_ready} !== 2'b01) $display("FAIL mid_release: got %b expected 01", {pipe_valid, res_ready}); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_label = '0; cmd_count = '0;
    sample_valid = 1'b0; pipe_ready = 1'b0; res_valid = 1'b0; res_label = '0; res_distance = '0;
    test_reset();
    test_train();
    test_predict_backpressure();
    test_stop_collision();
    test_result();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
